// File: rtl/qspi_receiver.sv
// Nibble-to-byte receiver for the Collector QSPI port: pairs nibbles high-first
// into bytes, queues them in a small FIFO and reports frame completion/errors.
module qspi_receiver #(
  parameter int DEPTH   = 8,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         qspi_data,
  input  logic               qspi_sending,
  output logic               qspi_ready,
  output logic [7:0]         byte_data,
  output logic               byte_valid,
  input  logic               byte_ready,
  output logic               frame_done,
  output logic               frame_error,
  output logic [COUNT_W-1:0] byte_count
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RX_HI,
    RX_LO
  } state_t;

  state_t        state;
  logic [3:0]    hi_nib;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;

  // Ready depends only on the registered count, so a pop frees space one cycle later.
  assign qspi_ready = (count < FULL_CNT);
  assign byte_valid = (count != '0);
  assign pop        = byte_valid && byte_ready;
  assign push       = qspi_sending && qspi_ready && (state == RX_LO);
  assign byte_data  = byte_valid ? mem[rd_ptr] : 8'h00;

  // Frame sequencing: the IDLE -> RX_HI transition consumes the first nibble
  // directly when space allows, so it lands in RX_LO.
  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      hi_nib      <= '0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      byte_count  <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (qspi_sending) begin
            byte_count <= '0;
            if (qspi_ready) begin
              hi_nib <= qspi_data;
              state  <= RX_LO;
            end else begin
              state  <= RX_HI;
            end
          end
        end
        RX_HI: begin
          if (!qspi_sending) begin
            state      <= IDLE;
            frame_done <= 1'b1;
          end else if (qspi_ready) begin
            hi_nib <= qspi_data;
            state  <= RX_LO;
          end
        end
        RX_LO: begin
          if (!qspi_sending) begin
            // Odd nibble count: drop the dangling high nibble and flag the frame.
            state       <= IDLE;
            hi_nib      <= '0;
            frame_error <= 1'b1;
          end else if (qspi_ready) begin
            if (byte_count != '1) begin
              byte_count <= byte_count + COUNT_W'(1);
            end
            state <= RX_HI;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO bookkeeping; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; emptiness is tracked by count and
  // byte_data is forced to zero while empty, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {hi_nib, qspi_data};
    end
  end

endmodule

// File: tb/tb_qspi_receiver.sv
// Directed bench for qspi_receiver: hand-computed byte streams, flow control,
// odd-frame error and asynchronous reset mid-frame.
module tb_qspi_receiver;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  qspi_data;
  logic        qspi_sending;
  logic        qspi_ready;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic        frame_done;
  logic        frame_error;
  logic [15:0] byte_count;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  qspi_receiver #(.DEPTH(8), .COUNT_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .qspi_data    (qspi_data),
    .qspi_sending (qspi_sending),
    .qspi_ready   (qspi_ready),
    .byte_data    (byte_data),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .frame_done   (frame_done),
    .frame_error  (frame_error),
    .byte_count   (byte_count)
  );

  always #5 clk = ~clk;

  // Inputs change 1 ns after the rising edge; the negative edge sees the
  // handshake that the next rising edge will act on.
  always @(negedge clk) begin
    if (reset) begin
      if (byte_valid && byte_ready) rx_q.push_back(byte_data);
      if (frame_done) done_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_nibble(input logic [3:0] n);
    int waits;
    logic took;
    waits = 0;
    qspi_sending = 1'b1;
    qspi_data    = n;
    forever begin
      took = qspi_ready;
      tick();
      if (took) break;
      waits++;
      if (waits > 50) begin
        check("ready_timeout", {31'd0, qspi_ready}, 32'd1);
        break;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_nibble(b[7:4]);
    send_nibble(b[3:0]);
    exp_q.push_back(b);
  endtask

  task automatic end_frame();
    qspi_sending = 1'b0;
    tick();
    tick();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (byte_valid && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) check("drain_timeout", {31'd0, byte_valid}, 32'd0);
    tick();
  endtask

  task automatic compare_q(input string tag);
    check({tag, "_len"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      check($sformatf("%s_b%0d", tag, i), {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
    end
  endtask

  task automatic clear_q();
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int d0;
    reset        = 1'b0;
    qspi_data    = 4'h0;
    qspi_sending = 1'b0;
    byte_ready   = 1'b0;
    tick();
    tick();
    check("rst_ready", {31'd0, qspi_ready}, 32'd1);
    check("rst_valid", {31'd0, byte_valid}, 32'd0);
    check("rst_data",  {24'd0, byte_data},  32'd0);
    check("rst_done",  {31'd0, frame_done}, 32'd0);
    check("rst_err",   {31'd0, frame_error}, 32'd0);
    check("rst_count", {16'd0, byte_count}, 32'd0);
    reset = 1'b1;
    tick();
    tick();
    check("idle_valid", {31'd0, byte_valid}, 32'd0);

    // Basic two-byte frame: 4,1,6,2 -> 0x41, 0x62.
    byte_ready = 1'b1;
    clear_q();
    d0 = done_cnt;
    send_nibble(4'h4);
    send_nibble(4'h1);
    check("lat_valid", {31'd0, byte_valid}, 32'd1);
    check("lat_data",  {24'd0, byte_data},  32'h41);
    send_nibble(4'h6);
    send_nibble(4'h2);
    qspi_sending = 1'b0;
    tick();
    check("done_pulse", {31'd0, frame_done}, 32'd1);
    tick();
    check("done_clear", {31'd0, frame_done}, 32'd0);
    drain();
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h62);
    compare_q("basic");
    check("basic_count", {16'd0, byte_count}, 32'd2);
    check("basic_ndone", done_cnt - d0, 32'd1);

    // Backpressure: 10 bytes with consumer stalled, resume without loss.
    byte_ready = 1'b0;
    clear_q();
    d0 = done_cnt;
    for (int i = 0; i < 7; i++) send_byte(8'(8'h10 + i * 8'h11));
    send_nibble(4'h8);
    check("bp_ready7", {31'd0, qspi_ready}, 32'd1);
    send_nibble(4'h7);
    exp_q.push_back(8'h87);
    check("bp_full", {31'd0, qspi_ready}, 32'd0);
    check("bp_head", {24'd0, byte_data}, 32'h10);
    qspi_data = 4'h9;
    tick();
    tick();
    tick();
    check("bp_hold_ready", {31'd0, qspi_ready}, 32'd0);
    check("bp_hold_count", {16'd0, byte_count}, 32'd8);
    byte_ready = 1'b1;
    check("bp_pop_pend", {31'd0, qspi_ready}, 32'd0);
    tick();
    check("bp_reopen", {31'd0, qspi_ready}, 32'd1);
    send_byte(8'h98);
    send_byte(8'hA9);
    end_frame();
    drain();
    compare_q("bp");
    check("bp_count", {16'd0, byte_count}, 32'd10);
    check("bp_ndone", done_cnt - d0, 32'd1);

    // Fill then stream through with pops; pointers wrap twice.
    byte_ready = 1'b0;
    clear_q();
    for (int i = 0; i < 8; i++) send_byte(8'(8'hC3 ^ (i * 8'h25)));
    check("wrap_full", {31'd0, qspi_ready}, 32'd0);
    byte_ready = 1'b1;
    for (int i = 8; i < 20; i++) send_byte(8'(8'hC3 ^ (i * 8'h25)));
    end_frame();
    drain();
    compare_q("wrap");
    check("wrap_count", {16'd0, byte_count}, 32'd20);

    // Odd-length frame A,B,C: one byte, sticky error, no done pulse.
    clear_q();
    d0 = done_cnt;
    send_nibble(4'hA);
    send_nibble(4'hB);
    send_nibble(4'hC);
    end_frame();
    drain();
    exp_q.push_back(8'hAB);
    compare_q("odd");
    check("odd_err",   {31'd0, frame_error}, 32'd1);
    check("odd_ndone", done_cnt - d0, 32'd0);
    check("odd_count", {16'd0, byte_count}, 32'd1);
    clear_q();
    send_byte(8'h5A);
    end_frame();
    drain();
    compare_q("after_odd");
    check("err_sticky", {31'd0, frame_error}, 32'd1);
    check("after_odd_ndone", done_cnt - d0, 32'd1);

    // Asynchronous reset between nibbles with three bytes queued.
    byte_ready = 1'b0;
    clear_q();
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_nibble(4'h4);
    check("pre_rst_valid", {31'd0, byte_valid}, 32'd1);
    #2;
    reset        = 1'b0;
    qspi_sending = 1'b0;
    #1;
    check("arst_valid", {31'd0, byte_valid}, 32'd0);
    check("arst_ready", {31'd0, qspi_ready}, 32'd1);
    check("arst_err",   {31'd0, frame_error}, 32'd0);
    check("arst_count", {16'd0, byte_count}, 32'd0);
    tick();
    reset      = 1'b1;
    byte_ready = 1'b1;
    tick();
    tick();
    tick();
    check("post_rst_valid", {31'd0, byte_valid}, 32'd0);
    check("post_rst_data",  {24'd0, byte_data},  32'd0);
    exp_q.delete();
    send_byte(8'h3C);
    end_frame();
    drain();
    compare_q("post_rst");
    check("post_rst_count", {16'd0, byte_count}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qspi_receiver.md
QSPI_RECEIVER -- requirements
Module: qspi_receiver

Interface
REQ-001 Parameter DEPTH, default 8, byte FIFO depth; SHALL be a power of two, minimum 2.
REQ-002 Parameter COUNT_W, default 16, width of the frame byte counter.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; assertion SHALL clear state immediately, independent of clk.
REQ-005 qspi_data  input  4  nibble from the Collector output port.
REQ-006 qspi_sending  input  1  Collector frame-active strobe; while high, one nibble is offered per cycle.
REQ-007 qspi_ready  output  1  receiver can accept a nibble this cycle.
REQ-008 byte_data  output  8  head-of-FIFO byte.
REQ-009 byte_valid  output  1  FIFO not empty.
REQ-010 byte_ready  input  1  downstream consumer accepts byte_data.
REQ-011 frame_done  output  1  one-cycle pulse at a clean frame end.
REQ-012 frame_error  output  1  sticky flag for a frame that ended on an odd nibble.
REQ-013 byte_count  output  COUNT_W  bytes assembled in the current or most recent frame.

Function
REQ-014 Nibble accept SHALL occur on a rising edge with qspi_sending=1 and qspi_ready=1; otherwise qspi_data is ignored.
REQ-015 qspi_ready SHALL be combinational: high when the FIFO count is less than DEPTH, low when full.
REQ-016 The FSM SHALL have states IDLE, RX_HI and RX_LO.
REQ-017 IDLE -> RX_HI when qspi_sending=1; the first nibble of the frame SHALL be accepted in that same cycle if qspi_ready=1.
REQ-018 RX_HI, on accept: qspi_data SHALL be stored as bits [7:4] of the byte; next state RX_LO.
REQ-019 RX_LO, on accept: {stored high nibble, qspi_data} SHALL be written to the FIFO tail, byte_count SHALL increment, next state RX_HI.
REQ-020 The FIFO write SHALL be visible on byte_valid/byte_data the cycle after the low-nibble accept (latency 1 cycle).
REQ-021 byte_count SHALL saturate at all-ones, SHALL clear to 0 on IDLE -> RX_HI, and SHALL hold its value in IDLE.
REQ-022 Falling qspi_sending in RX_HI (even nibble count): next state IDLE; frame_done SHALL pulse high for exactly one cycle.
REQ-023 Falling qspi_sending in RX_LO (odd nibble count): the partial high nibble SHALL be discarded, nothing SHALL be written, frame_error SHALL set, frame_done SHALL NOT pulse, next state IDLE.
REQ-024 frame_error SHALL stay set until reset and SHALL NOT be cleared by a later good frame.
REQ-025 Pop SHALL occur when byte_valid=1 and byte_ready=1; the head pointer SHALL advance and byte_data SHALL show the next entry the following cycle.
REQ-026 Simultaneous push and pop SHALL keep the count unchanged and SHALL preserve order.
REQ-027 Pointers SHALL wrap modulo DEPTH; the count SHALL range 0..DEPTH.
REQ-028 When the FIFO is full, no nibble SHALL be accepted and the FSM state SHALL hold. A pop in that cycle SHALL raise qspi_ready in the next cycle only.
REQ-029 When empty, byte_data SHALL be don't-care and byte_ready SHALL have no effect.

Reset
REQ-030 While reset=0: FSM = IDLE, FIFO empty, pointers 0, qspi_ready=1, byte_valid=0, byte_data=0, frame_done=0, frame_error=0, byte_count=0.
REQ-031 Reset asserted mid-frame SHALL discard the partial byte and all FIFO contents; after release the receiver SHALL wait in IDLE until qspi_sending is seen high.

Verification
REQ-032 Nibbles 4,1,6,2 with byte_ready=1 -> bytes 0x41 then 0x62 in order, byte_count=2, one frame_done pulse after sending falls.
REQ-033 byte_ready=0 and 10 bytes sent -> qspi_ready falls after byte 8; on release the bytes pop in order, and nibbles resume exactly where they stopped, with none lost or duplicated.
REQ-034 Frame of nibbles A,B,C then sending falls -> single byte 0xAB written, frame_error=1, no frame_done; a next good frame 0x5A -> byte 0x5A, frame_error still 1.
REQ-035 Full FIFO with byte_ready=1 and sending=1 held -> sustained push and pop; count stays constant across pointer wrap; output matches input.
REQ-036 reset pulsed low asynchronously between the nibbles of a byte with 3 bytes queued -> byte_valid=0 immediately; no stale byte appears after release.
